weight_mem_ctrl: RTL and testbench
==================================

# weight_mem_ctrl

Controller that owns the single port of one projection-weight memory (Wq/Wk/Wv, 64-bit words, one weight row = 128 int8 = 16 words). It shares that port between a host/DMA preload writer and the compute-side weight fetch. It sequences row-burst reads, absorbs the memory's one-cycle registered read latency, and delivers words on a valid/ready stream to the PE array.

## Interface
Parameters:
- WIDTH, 64, memory word width
- WEIGHT_BASE, 0, word address of row 0
- ROW_WORDS, 16, words per weight row
- NUM_ROWS, 128, rows in the weight matrix

Ports:
- clk  in  1  clock; all logic on posedge
- rst  in  1  synchronous, active-high reset
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted this cycle
- wr_addr  in  32  host word address
- wr_data  in  WIDTH  host write data
- rd_start  in  1  burst request pulse, sampled in IDLE only
- rd_row_base  in  8  first row of burst
- rd_row_cnt  in  8  rows to fetch (0 allowed)
- out_valid  out  1  stream word valid
- out_ready  in  1  consumer ready
- out_data  out  WIDTH  weight word
- out_last  out  1  final word of burst
- busy  out  1  burst in progress
- done  out  1  one-cycle burst-complete pulse
- mem_write_en  out  1  to memory (1 write, 0 read)
- mem_addr  out  32  to memory
- mem_data_in  out  WIDTH  to memory
- mem_data_out  in  WIDTH  from memory; registered, valid the cycle after a read-address cycle

## Operation
- States: IDLE, READ, DRAIN, DONE.
- IDLE:
  - rd_start=1 latches base/count, clears counters. Goes to READ, or to DONE if rd_row_cnt=0.
  - rd_start has priority over wr_valid; wr_ready=0 in that cycle.
- Host write: wr_ready = (state==IDLE) && !rd_start && !rst.
  - On wr_valid&&wr_ready: mem_write_en=1, mem_addr=wr_addr, mem_data_in=wr_data in the same cycle (combinational).
  - wr_ready=0 in every other state.
- READ: issues one read per cycle while occupancy+inflight < 3.
  - occupancy = output FIFO entries; inflight = 1 if a read was issued last cycle.
  - Address = WEIGHT_BASE + ((rd_row_base+r) mod NUM_ROWS)*ROW_WORDS + w.
  - w counts 0..ROW_WORDS-1 and increments r on wrap. Row index wraps modulo NUM_ROWS.
  - After the last issue (rd_row_cnt*ROW_WORDS words, 12-bit counter), go to DRAIN.
- Capture: the cycle after an issue, mem_data_out is pushed into a 3-entry FIFO with a last flag. last=1 only for the final word.
- DRAIN: wait until the FIFO is empty and nothing is inflight, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- busy=1 in READ, DRAIN and DONE.
- out_valid = FIFO non-empty. out_data/out_last = FIFO head. Pop on out_valid&&out_ready.
- out_data/out_last must hold stable while out_valid && !out_ready.
- mem_write_en=0 in all states except an accepted host write. mem_addr=0 when neither writing nor issuing.

## Timing
- Reset values: state IDLE, FIFO empty, inflight 0.
  - out_valid=0, out_last=0, out_data=0, busy=0, done=0.
  - wr_ready=0 while rst=1, mem_write_en=0, mem_addr=0, mem_data_in=0.
- Reset mid-burst: flushes FIFO and inflight. No done pulse. IDLE on the next cycle.
- Burst timing, start accepted at cycle 0:
  - first read address at cycle 1;
  - mem_data_out valid at cycle 2, pushed at end of cycle 2;
  - out_valid at cycle 3.
- With out_ready held 1: one word per cycle, no bubbles. The last word is at cycle N+2 for N words. done is asserted at cycle N+3.
- rd_row_cnt=0: DONE at cycle 1 (done=1), IDLE at cycle 2, no out_valid.
- Backpressure: issue stalls when occupancy+inflight=3. No word is lost or duplicated. The FIFO never overflows.
- rd_start outside IDLE is ignored.

## Structure
- Package weight_mem_pkg holds:
  - state enum (IDLE, READ, DRAIN, DONE);
  - ROW_WORDS/NUM_ROWS defaults;
  - FIFO_DEPTH=3;
  - counter width constant (12).
- One sub-module, weight_out_fifo: 3-entry synchronous FIFO of {last, data}, with push/pop/count, same clk/rst.
- Controller FSM, address generator and credit logic stay in weight_mem_ctrl.

## Test plan
- Host preload: write addr 5 = 64'hDEAD_BEEF_0000_0005 in IDLE.
  - Expect wr_ready=1, mem_write_en=1, mem_addr=5 that cycle.
  - A following burst of row 0 returns that word at beat 5.
- Single row: rd_row_base=3, rd_row_cnt=1, out_ready=1.
  - Expect addresses 48..63 on cycles 1..16.
  - Expect 16 beats on cycles 3..18, out_last on beat 16, done at cycle 19.
- Wrap: rd_row_base=127, rd_row_cnt=2.
  - Expect addresses 2032..2047 then 0..15, 32 beats, a single out_last.
- Backpressure: 2-row burst with out_ready toggling 1/0 every 3 cycles.
  - Expect the data sequence identical to the out_ready=1 run.
  - Stable out_data while stalled; never more than 3 words buffered.
- Zero count and contention: rd_start with rd_row_cnt=0 and wr_valid=1 in the same cycle.
  - Expect wr_ready=0, done at cycle 1, write accepted at cycle 2.
- Reset mid-burst: assert rst at beat 7 of a 1-row burst.
  - Expect out_valid=0, busy=0, no done.
  - A new burst afterwards starts cleanly from its first address.

Source files
------------

// File: rtl/weight_mem_pkg.sv
// Shared types and constants for the projection-weight memory controller.
package weight_mem_pkg;

  localparam int ROW_WORDS_DEF = 16;
  localparam int NUM_ROWS_DEF  = 128;
  localparam int FIFO_DEPTH    = 3;
  localparam int CNT_W         = 12;

  typedef enum logic [1:0] {
    IDLE,
    READ,
    DRAIN,
    DONE
  } state_e;

endpackage

// File: rtl/weight_out_fifo.sv
// 3-entry {last, data} FIFO; head visible combinationally, push lands the next cycle.
// Push while full is refused unless a pop frees a slot in the same cycle.
module weight_out_fifo
  import weight_mem_pkg::*;
#(
  parameter int WIDTH = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_i,
  input  logic             push_last_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic             head_last_o,
  output logic [WIDTH-1:0] head_data_o,
  output logic [1:0]       count_o
);

  logic [WIDTH:0] mem_q [FIFO_DEPTH];
  logic [1:0]     rd_ptr_q, rd_ptr_d;
  logic [1:0]     wr_ptr_q, wr_ptr_d;
  logic [1:0]     count_q, count_d;
  logic           do_push, do_pop;

  assign do_pop  = pop_i && (count_q != 2'd0);
  assign do_push = push_i && ((count_q != 2'(FIFO_DEPTH)) || do_pop);

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (do_pop) begin
      rd_ptr_d = (rd_ptr_q == 2'(FIFO_DEPTH - 1)) ? 2'd0 : rd_ptr_q + 2'd1;
    end
    if (do_push) begin
      wr_ptr_d = (wr_ptr_q == 2'(FIFO_DEPTH - 1)) ? 2'd0 : wr_ptr_q + 2'd1;
    end
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + 2'd1;
      2'b01:   count_d = count_q - 2'd1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr_q <= 2'd0;
      wr_ptr_q <= 2'd0;
      count_q  <= 2'd0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      if (do_push) begin
        mem_q[wr_ptr_q] <= {push_last_i, push_data_i};
      end
    end
  end

  assign head_last_o = mem_q[rd_ptr_q][WIDTH];
  assign head_data_o = mem_q[rd_ptr_q][WIDTH-1:0];
  assign count_o     = count_q;

endmodule

// File: rtl/weight_mem_ctrl.sv
// Arbitrates the weight-memory port between host preload and row-burst fetch; first
// word streams 3 cycles after start, and reads stall on credit so the FIFO never overflows.
module weight_mem_ctrl
  import weight_mem_pkg::*;
#(
  parameter int WIDTH       = 64,
  parameter int WEIGHT_BASE = 0,
  parameter int ROW_WORDS   = ROW_WORDS_DEF,
  parameter int NUM_ROWS    = NUM_ROWS_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             wr_valid,
  output logic             wr_ready,
  input  logic [31:0]      wr_addr,
  input  logic [WIDTH-1:0] wr_data,
  input  logic             rd_start,
  input  logic [7:0]       rd_row_base,
  input  logic [7:0]       rd_row_cnt,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_last,
  output logic             busy,
  output logic             done,
  output logic             mem_write_en,
  output logic [31:0]      mem_addr,
  output logic [WIDTH-1:0] mem_data_in,
  input  logic [WIDTH-1:0] mem_data_out
);

  state_e           state_q, state_d;
  logic [7:0]       row_q, row_d;
  logic [CNT_W-1:0] word_q, word_d;
  logic [CNT_W-1:0] issued_q, issued_d;
  logic [CNT_W-1:0] total_q, total_d;
  logic             inflight_q, inflight_last_q;

  logic [1:0]  fifo_cnt;
  logic [2:0]  credit_used;
  logic        issue, issue_last, pop, wr_fire;
  logic [31:0] issue_addr;

  // A read in flight already owns a FIFO slot, so it counts against the credit.
  assign credit_used = 3'(fifo_cnt) + 3'(inflight_q);
  assign issue       = (state_q == READ) && !rst && (credit_used < 3'(FIFO_DEPTH));
  assign issue_last  = (issued_q == total_q - CNT_W'(1));
  assign issue_addr  = 32'(WEIGHT_BASE) + 32'(row_q) * 32'(ROW_WORDS) + 32'(word_q);

  assign out_valid = (fifo_cnt != 2'd0);
  assign pop       = out_valid && out_ready;

  assign wr_ready     = (state_q == IDLE) && !rd_start && !rst;
  assign wr_fire      = wr_valid && wr_ready;
  assign mem_write_en = wr_fire;
  assign mem_addr     = wr_fire ? wr_addr : (issue ? issue_addr : 32'd0);
  assign mem_data_in  = wr_fire ? wr_data : '0;

  always_comb begin
    state_d  = state_q;
    row_d    = row_q;
    word_d   = word_q;
    issued_d = issued_q;
    total_d  = total_q;
    done     = 1'b0;
    busy     = (state_q != IDLE) && !rst;
    case (state_q)
      IDLE: begin
        if (rd_start) begin
          row_d    = 8'(32'(rd_row_base) % NUM_ROWS);
          word_d   = '0;
          issued_d = '0;
          total_d  = CNT_W'(32'(rd_row_cnt) * 32'(ROW_WORDS));
          state_d  = (rd_row_cnt == 8'd0) ? DONE : READ;
        end
      end
      READ: begin
        if (issue) begin
          issued_d = issued_q + CNT_W'(1);
          if (word_q == CNT_W'(ROW_WORDS - 1)) begin
            word_d = '0;
            row_d  = (row_q == 8'(NUM_ROWS - 1)) ? 8'd0 : row_q + 8'd1;
          end else begin
            word_d = word_q + CNT_W'(1);
          end
          if (issue_last) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        // Leave as the last word pops so done lands the cycle after it.
        if (!inflight_q && ((fifo_cnt == 2'd0) || ((fifo_cnt == 2'd1) && pop))) begin
          state_d = DONE;
        end
      end
      DONE: begin
        done    = !rst;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q         <= IDLE;
      row_q           <= 8'd0;
      word_q          <= '0;
      issued_q        <= '0;
      total_q         <= '0;
      inflight_q      <= 1'b0;
      inflight_last_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      row_q           <= row_d;
      word_q          <= word_d;
      issued_q        <= issued_d;
      total_q         <= total_d;
      inflight_q      <= issue;
      inflight_last_q <= issue && issue_last;
    end
  end

  weight_out_fifo #(
    .WIDTH(WIDTH)
  ) u_out_fifo (
    .clk         (clk),
    .rst         (rst),
    .push_i      (inflight_q),
    .push_last_i (inflight_last_q),
    .push_data_i (mem_data_out),
    .pop_i       (pop),
    .head_last_o (out_last),
    .head_data_o (out_data),
    .count_o     (fifo_cnt)
  );

endmodule

// File: tb/tb_weight_mem_ctrl.sv
// Directed bench for weight_mem_ctrl with a registered single-port memory model.
module tb_weight_mem_ctrl;

  logic        clk;
  logic        rst;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_addr;
  logic [63:0] wr_data;
  logic        rd_start;
  logic [7:0]  rd_row_base;
  logic [7:0]  rd_row_cnt;
  logic        out_valid;
  logic        out_ready;
  logic [63:0] out_data;
  logic        out_last;
  logic        busy;
  logic        done;
  logic        mem_write_en;
  logic [31:0] mem_addr;
  logic [63:0] mem_data_in;
  logic [63:0] mem_data_out;

  int n_cmp;
  int n_fail;
  bit preloaded;
  logic [63:0] mem [4096];
  logic [63:0] cap [64];

  localparam logic [63:0] PRELOAD_WORD = 64'hDEAD_BEEF_0000_0005;

  weight_mem_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .wr_valid     (wr_valid),
    .wr_ready     (wr_ready),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .rd_start     (rd_start),
    .rd_row_base  (rd_row_base),
    .rd_row_cnt   (rd_row_cnt),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .out_data     (out_data),
    .out_last     (out_last),
    .busy         (busy),
    .done         (done),
    .mem_write_en (mem_write_en),
    .mem_addr     (mem_addr),
    .mem_data_in  (mem_data_in),
    .mem_data_out (mem_data_out)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    if (mem_write_en) mem[mem_addr[11:0]] <= mem_data_in;
    mem_data_out <= mem[mem_addr[11:0]];
  end

  function automatic logic [63:0] pat(input logic [31:0] a);
    return {16'hC0DE, a[15:0], ~a[15:0], a[15:0] ^ 16'h5A5A};
  endfunction

  function automatic logic [63:0] exp_data(input logic [31:0] a);
    if (preloaded && a == 32'd5) return PRELOAD_WORD;
    return pat(a);
  endfunction

  function automatic logic [31:0] exp_addr(input logic [7:0] base, input int k);
    return 32'((((int'(base) + k / 16) % 128) * 16) + (k % 16));
  endfunction

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, got, exp);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Runs one burst starting in the current cycle; returns one cycle after done.
  task automatic run_burst(input logic [7:0] base, input logic [7:0] cnt, input bit bp,
                           input int exp_beats, input int exp_done, input logic [31:0] exp_first);
    int beats, done_cyc, first_cyc, last_cyc;
    bit stalled;
    logic [63:0] held;
    beats = 0; done_cyc = -1; first_cyc = -1; last_cyc = -1; stalled = 1'b0; held = '0;
    for (int c = 0; c < 600 && done_cyc < 0; c++) begin
      rd_start    = (c == 0) || (c == 5);
      rd_row_base = (c == 0) ? base : 8'h55;
      rd_row_cnt  = (c == 0) ? cnt : 8'd9;
      out_ready   = bp ? (((c / 3) % 2) == 0) : 1'b1;
      @(negedge clk);
      if (c == 0) begin
        chk("start_wr_ready", wr_ready, 0);
        chk("start_busy", busy, 0);
      end else begin
        chk("burst_busy", busy, 1);
      end
      if (c == 1) chk("first_addr", mem_addr, exp_first);
      if (!bp && c >= 1 && c <= exp_beats) chk("rd_addr", mem_addr, exp_addr(base, c - 1));
      if (stalled) begin
        chk("stall_valid", out_valid, 1);
        chk("stall_data", out_data, held);
      end
      stalled = out_valid && !out_ready;
      held    = out_data;
      if (out_valid && out_ready) begin
        chk("beat_data", out_data, exp_data(exp_addr(base, beats)));
        chk("beat_last", out_last, (beats == exp_beats - 1));
        if (beats < 64) cap[beats] = out_data;
        if (first_cyc < 0) first_cyc = c;
        last_cyc = c;
        beats++;
      end
      if (done) done_cyc = c;
      next_cycle();
    end
    rd_start = 1'b0;
    @(negedge clk);
    chk("done_seen", (done_cyc >= 0), 1);
    chk("beat_count", beats, exp_beats);
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", out_valid, 0);
    if (exp_done >= 0) begin
      chk("done_cycle", done_cyc, exp_done);
      chk("first_beat_cycle", first_cyc, 3);
      chk("last_beat_cycle", last_cyc, exp_beats + 2);
    end
    next_cycle();
  endtask

  typedef struct {
    logic [7:0]  base;
    logic [7:0]  cnt;
    bit          bp;
    int          beats;
    int          done_cyc;
    logic [31:0] first;
  } vec_t;

  vec_t tbl [4];

  initial begin
    int dn;
    n_cmp = 0; n_fail = 0; preloaded = 1'b0;
    for (int i = 0; i < 4096; i++) mem[i] = pat(32'(i));

    tbl[0] = '{base: 8'd3,   cnt: 8'd1, bp: 1'b0, beats: 16, done_cyc: 19, first: 32'd48};
    tbl[1] = '{base: 8'd127, cnt: 8'd2, bp: 1'b0, beats: 32, done_cyc: 35, first: 32'd2032};
    tbl[2] = '{base: 8'd10,  cnt: 8'd2, bp: 1'b1, beats: 32, done_cyc: -1, first: 32'd160};
    tbl[3] = '{base: 8'd200, cnt: 8'd1, bp: 1'b0, beats: 16, done_cyc: 19, first: 32'd1152};

    rst = 1'b1; wr_valid = 1'b1; wr_addr = 32'd9; wr_data = 64'h1234;
    rd_start = 1'b0; rd_row_base = 8'd0; rd_row_cnt = 8'd0; out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_mem_we", mem_write_en, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_mem_din", mem_data_in, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_last", out_last, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    next_cycle();
    rst = 1'b0; wr_valid = 1'b0;
    next_cycle();

    wr_valid = 1'b1; wr_addr = 32'd5; wr_data = PRELOAD_WORD;
    @(negedge clk);
    chk("pre_wr_ready", wr_ready, 1);
    chk("pre_mem_we", mem_write_en, 1);
    chk("pre_mem_addr", mem_addr, 5);
    chk("pre_mem_din", mem_data_in, PRELOAD_WORD);
    next_cycle();
    wr_valid = 1'b0; preloaded = 1'b1;
    run_burst(8'd0, 8'd1, 1'b0, 16, 19, 32'd0);
    chk("preload_beat5", cap[5], PRELOAD_WORD);

    for (int i = 0; i < 4; i++) begin
      run_burst(tbl[i].base, tbl[i].cnt, tbl[i].bp, tbl[i].beats, tbl[i].done_cyc, tbl[i].first);
    end

    rd_start = 1'b1; rd_row_base = 8'd0; rd_row_cnt = 8'd0;
    wr_valid = 1'b1; wr_addr = 32'd4000; wr_data = 64'hABCD_0000_0FA0;
    out_ready = 1'b1;
    @(negedge clk);
    chk("zc_c0_wr_ready", wr_ready, 0);
    chk("zc_c0_mem_we", mem_write_en, 0);
    next_cycle();
    rd_start = 1'b0;
    @(negedge clk);
    chk("zc_c1_done", done, 1);
    chk("zc_c1_wr_ready", wr_ready, 0);
    chk("zc_c1_valid", out_valid, 0);
    next_cycle();
    @(negedge clk);
    chk("zc_c2_wr_ready", wr_ready, 1);
    chk("zc_c2_mem_we", mem_write_en, 1);
    chk("zc_c2_mem_addr", mem_addr, 4000);
    chk("zc_c2_done", done, 0);
    chk("zc_c2_busy", busy, 0);
    next_cycle();
    wr_valid = 1'b0;
    next_cycle();

    for (int c = 0; c <= 9; c++) begin
      rd_start = (c == 0); rd_row_base = 8'd3; rd_row_cnt = 8'd1;
      rst = (c == 9);
      @(negedge clk);
      if (c == 8) chk("mid_valid", out_valid, 1);
      if (c == 9) begin
        chk("mid_rst_mem_addr", mem_addr, 0);
        chk("mid_rst_done", done, 0);
      end
      next_cycle();
    end
    rst = 1'b0; rd_start = 1'b0;
    @(negedge clk);
    chk("after_rst_valid", out_valid, 0);
    chk("after_rst_busy", busy, 0);
    chk("after_rst_last", out_last, 0);
    dn = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (done || out_valid) dn++;
      next_cycle();
    end
    chk("after_rst_quiet", dn, 0);
    run_burst(8'd5, 8'd1, 1'b0, 16, 19, 32'd80);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end

endmodule
